maj_fold_ctrl: RTL and testbench

//   Folded majority/threshold evaluator. Time-multiplexes one W-input popcount slice over an
//   N-bit vector, accumulating the ones-count, then compares against a per-request threshold.

---
 rtl/maj_fold_ctrl.sv | 132 +++++++++++++
 tb/tb_maj_fold_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maj_fold_ctrl.sv
// maj_fold_ctrl: folded threshold/majority evaluator.
// Accepts an N-bit vector plus a threshold, counts its ones W bits per cycle
// over NCH = ceil(N/W) RUN cycles, then holds {count, count >= threshold}
// until the consumer takes it.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   request handshake (ready only in IDLE)
//   in_vec, in_thr        request payload, sampled on the accept cycle only
//   out_valid / out_ready result handshake
//   out_y, out_count      threshold decision and ones-count (registered)
//   busy                  high while a request is in flight (RUN or DONE)
module maj_fold_ctrl #(
    parameter int unsigned N  = 15,
    parameter int unsigned W  = 5,
    localparam int unsigned CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_vec,
    input  logic [CW-1:0] in_thr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_y,
    output logic [CW-1:0] out_count,
    output logic          busy
);

    localparam int unsigned NCH = (N + W - 1) / W;
    localparam int unsigned PW  = NCH * W;
    localparam int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e        state_q;
    logic [PW-1:0] vec_q;
    logic [CW-1:0] thr_q;
    logic [CW-1:0] acc_q;
    logic [CW-1:0] acc_d;
    logic [IW-1:0] idx_q;
    logic [W-1:0]  chunk;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          out_y_q;
    logic [CW-1:0] out_count_q;
    logic          busy_q;

    // Select the current W-bit slice; vec_q is zero-padded up to PW bits.
    always_comb begin
        chunk = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (idx_q == IW'(i)) begin
                chunk = vec_q[i*W +: W];
            end
        end
    end

    // Running ones-count including the current slice.
    always_comb begin
        acc_d = acc_q;
        for (int j = 0; j < int'(W); j++) begin
            acc_d = acc_d + CW'(chunk[j]);
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            vec_q       <= '0;
            thr_q       <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_y_q     <= 1'b0;
            out_count_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        vec_q      <= PW'(in_vec);
                        thr_q      <= in_thr;
                        acc_q      <= '0;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + IW'(1);
                    if (idx_q == IW'(NCH - 1)) begin
                        out_valid_q <= 1'b1;
                        out_count_q <= acc_d;
                        out_y_q     <= (acc_d >= thr_q);
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // No re-accept here; IDLE is always visited between requests.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_count = out_count_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_maj_fold_ctrl.sv
// tb_maj_fold_ctrl: scoreboard bench for three maj_fold_ctrl configurations
// (N=15/W=5, N=5/W=5, N=7/W=3). Drivers push expected results computed from
// a whole-vector ones-count; a monitor pops and compares on each handshake.
module tb_maj_fold_ctrl;

    typedef struct {
        int cnt;
        int y;
        int tacc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        iv   [3];
    logic        ir   [3];
    logic [14:0] vec  [3];
    logic [3:0]  thr  [3];
    logic        ov   [3];
    logic        ordy [3];
    logic        oy   [3];
    logic        bs   [3];
    logic [3:0]  oc0;
    logic [2:0]  oc1;
    logic [2:0]  oc2;

    int   n_tests;
    int   n_fail;
    int   cyc;
    bit   rdy_rand;
    bit   pv  [3];
    bit   hsp [3];
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    maj_fold_ctrl #(.N(15), .W(5)) u_d0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_vec(vec[0]), .in_thr(thr[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_y(oy[0]), .out_count(oc0), .busy(bs[0])
    );

    maj_fold_ctrl #(.N(5), .W(5)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_vec(vec[1][4:0]), .in_thr(thr[1][2:0]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_y(oy[1]), .out_count(oc1), .busy(bs[1])
    );

    maj_fold_ctrl #(.N(7), .W(3)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_vec(vec[2][6:0]), .in_thr(thr[2][2:0]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out_y(oy[2]), .out_count(oc2), .busy(bs[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int nbits(int d);
        return (d == 0) ? 15 : (d == 1) ? 5 : 7;
    endfunction

    function automatic int tbits(int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic int nchunks(int d);
        return (d == 0) ? 3 : (d == 1) ? 1 : 3;
    endfunction

    function automatic int get_cnt(int d);
        return (d == 0) ? int'(oc0) : (d == 1) ? int'(oc1) : int'(oc2);
    endfunction

    function automatic int qsize(int d);
        return (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
    endfunction

    function automatic exp_t qfront(int d);
        return (d == 0) ? q0[0] : (d == 1) ? q1[0] : q2[0];
    endfunction

    task automatic qpop(int d);
        if (d == 0) void'(q0.pop_front());
        else if (d == 1) void'(q1.pop_front());
        else void'(q2.pop_front());
    endtask

    task automatic qpush(int d, exp_t e);
        if (d == 0) q0.push_back(e);
        else if (d == 1) q1.push_back(e);
        else q2.push_back(e);
    endtask

    task automatic check(string name, int d, int act, int expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s dut%0d @cyc %0d: got %0d expected %0d", name, d, cyc, act, expv);
        end
    endtask

    task automatic fail_now(string name, int d);
        n_tests++;
        n_fail++;
        $display("FAIL %s dut%0d @cyc %0d", name, d, cyc);
    endtask

    // Reference: whole-vector ones-count against the threshold.
    function automatic exp_t model(int d, logic [14:0] v, logic [3:0] t, int tacc);
        exp_t        e;
        logic [14:0] m;
        int          tv;
        m      = 15'((32'd1 << nbits(d)) - 1);
        tv     = int'(t) & ((1 << tbits(d)) - 1);
        e.cnt  = $countones(v & m);
        e.y    = (e.cnt >= tv) ? 1 : 0;
        e.tacc = tacc;
        return e;
    endfunction

    // Monitor: sampled 2 time units after the falling edge.
    always begin
        @(negedge clk);
        #2;
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                pv[d]  = 1'b0;
                hsp[d] = 1'b0;
                if (d == 0) q0.delete();
                else if (d == 1) q1.delete();
                else q2.delete();
            end else begin
                if (hsp[d]) check("valid_drop", d, int'(ov[d]), 0);
                if (ov[d]) begin
                    if (qsize(d) == 0) begin
                        fail_now("spurious_valid", d);
                    end else begin
                        exp_t e;
                        e = qfront(d);
                        if (!pv[d]) check("latency", d, cyc, e.tacc + nchunks(d) + 1);
                        check("count", d, get_cnt(d), e.cnt);
                        check("y", d, int'(oy[d]), e.y);
                        check("busy_done", d, int'(bs[d]), 1);
                        if (ordy[d]) qpop(d);
                    end
                end
                hsp[d] = ov[d] && ordy[d];
                pv[d]  = ov[d];
            end
        end
    end

    // Random consumer backpressure.
    always @(negedge clk) begin
        if (rdy_rand) begin
            for (int d = 0; d < 3; d++) ordy[d] = (($urandom % 4) != 0);
        end
    end

    task automatic issue(int d, logic [14:0] v, logic [3:0] t);
        int g;
        g = 0;
        @(negedge clk);
        vec[d] = v;
        thr[d] = t;
        iv[d]  = 1'b1;
        while (!ir[d]) begin
            @(negedge clk);
            g++;
            if (g > 500) begin
                fail_now("accept_timeout", d);
                iv[d] = 1'b0;
                return;
            end
        end
        qpush(d, model(d, v, t, cyc));
        @(posedge clk);
        #1;
        iv[d]  = 1'b0;
        vec[d] = 15'($urandom);
        thr[d] = 4'($urandom);
    endtask

    task automatic drain(int d);
        int g;
        g = 0;
        while ((qsize(d) != 0 || ov[d]) && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) fail_now("drain_timeout", d);
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        cyc      = 0;
        rdy_rand = 1'b0;
        rst      = 1'b1;
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0; vec[d] = '0; thr[d] = '0; ordy[d] = 1'b1;
            pv[d] = 1'b0; hsp[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check("rst_in_ready", d, int'(ir[d]), 1);
            check("rst_out_valid", d, int'(ov[d]), 0);
            check("rst_out_y", d, int'(oy[d]), 0);
            check("rst_out_count", d, get_cnt(d), 0);
            check("rst_busy", d, int'(bs[d]), 0);
        end

        // Directed cases on N=15, W=5.
        issue(0, 15'h7FFF, 4'd8);
        issue(0, 15'h00FF, 4'd8);
        issue(0, 15'h007F, 4'd8);
        issue(0, 15'h0000, 4'd0);
        issue(0, 15'h7FFF, 4'd15);
        issue(0, 15'h7FFE, 4'd15);
        drain(0);
        check("hold_count", 0, get_cnt(0), 14);
        check("hold_y", 0, int'(oy[0]), 0);

        // Backpressure in DONE with a pending request.
        ordy[0] = 1'b0;
        issue(0, 15'h1234, 4'd5);
        begin
            int g;
            g = 0;
            while (!ov[0] && g < 50) begin @(negedge clk); g++; end
            if (g >= 50) fail_now("bp_valid_timeout", 0);
        end
        vec[0] = 15'h0F0F;
        thr[0] = 4'd9;
        iv[0]  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", 0, int'(ir[0]), 0);
            check("bp_out_valid", 0, int'(ov[0]), 1);
        end
        ordy[0] = 1'b1;
        issue(0, 15'h0F0F, 4'd9);
        drain(0);

        // Reset in the middle of RUN.
        issue(0, 15'h5555, 4'd4);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", 0, int'(ir[0]), 1);
        check("midrst_out_valid", 0, int'(ov[0]), 0);
        check("midrst_busy", 0, int'(bs[0]), 0);
        repeat (6) @(negedge clk);
        issue(0, 15'h3C3C, 4'd8);
        drain(0);

        // Maj5 sweep and thresholds above N.
        for (int v = 0; v < 32; v++) issue(1, 15'(v), 4'd3);
        issue(1, 15'h001F, 4'd6);
        issue(1, 15'h001F, 4'd7);
        issue(1, 15'h0000, 4'd0);
        drain(1);

        // Zero-padded last chunk on N=7, W=3.
        issue(2, 15'h0040, 4'd1);
        issue(2, 15'h0040, 4'd2);
        issue(2, 15'h007F, 4'd7);
        drain(2);

        // Randomised traffic on all three with random backpressure.
        rdy_rand = 1'b1;
        fork
            for (int k = 0; k < 40; k++) issue(0, 15'($urandom), 4'($urandom_range(0, 15)));
            for (int k = 0; k < 40; k++) issue(1, 15'($urandom), 4'($urandom_range(0, 7)));
            for (int k = 0; k < 40; k++) issue(2, 15'($urandom), 4'($urandom_range(0, 7)));
        join
        rdy_rand = 1'b0;
        for (int d = 0; d < 3; d++) ordy[d] = 1'b1;
        for (int d = 0; d < 3; d++) drain(d);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
